// File: rtl/ahbsram_pkg.sv
// Shared types and helpers for the AHB SRAM controller.
// State encoding, transfer size codes, lane-index width.
package ahbsram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_ERR
    } state_e;

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;

    // log2 of the number of byte lanes in one data word
    function automatic int lane_bits(input int dw);
        int n;
        int r;
        n = dw / 8;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (n > 1) begin
                n = n >> 1;
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ahbsram_byteen_dec.sv
// Byte-lane write-enable decoder.
// Shifts a size-dependent lane mask to the addressed byte offset.
module ahbsram_byteen_dec
    import ahbsram_pkg::*;
#(
    parameter  int DWIDTH = 32,
    localparam int NB     = DWIDTH / 8,
    localparam int K      = lane_bits(DWIDTH)
) (
    input  logic          en_i,
    input  logic [2:0]    size_i,
    input  logic [K-1:0]  off_i,
    output logic [NB-1:0] byteen_o
);

    logic [NB-1:0] base;

    // Lane mask for the transfer size, placed at the byte offset
    always_comb begin
        base = '0;
        unique case (1'b1)
            (size_i == SZ_BYTE):  base = NB'(1);
            (size_i == SZ_HALF):  base = NB'(3);
            (size_i == SZ_WORD):  base = NB'(15);
            (size_i == SZ_DWORD): base = '1;
            default:              base = '0;
        endcase
        byteen_o = en_i ? (base << off_i) : '0;
    end

endmodule

// File: rtl/ahbsram_ctrl_pipe.sv
// SRAM controller behind an AHB bus interface.
// Single-cycle writes, fixed-latency reads, back-to-back acceptance.
module ahbsram_ctrl_pipe
    import ahbsram_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 19,
    parameter int RD_LATENCY = 1
) (
    input  logic                HCLK,
    input  logic                aresetn,
    input  logic                req,
    input  logic                write,
    input  logic [2:0]          size,
    input  logic [AWIDTH-1:0]   addr,
    input  logic [DWIDTH-1:0]   wdata,
    output logic                ack,
    output logic                err,
    output logic [DWIDTH-1:0]   rdata,
    output logic                busy,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [DWIDTH/8-1:0] mem_byteen,
    output logic [DWIDTH-1:0]   mem_wdata,
    input  logic [DWIDTH-1:0]   mem_rdata
);

    localparam int K = lane_bits(DWIDTH);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] rdata_q;
    logic              accept;
    logic              illegal;
    logic              cap;
    logic [2:0]        amask;

    assign mem_addr  = addr >> K;
    assign mem_wdata = wdata;
    assign rdata     = rdata_q;

    // Acceptance, legality, strobes and next state
    always_comb begin
        ack     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        unique case (state_q)
            ST_WR, ST_ERR: ack = 1'b1;
            ST_RD:         ack = (cnt_q == 2'd0);
            default:       ack = 1'b0;
        endcase
        err     = ack && (state_q == ST_ERR);
        busy    = (state_q != ST_IDLE);
        amask   = 3'((4'd1 << size[1:0]) - 4'd1);
        illegal = (size > 3'(K)) || (|(addr[2:0] & amask));
        accept  = aresetn && req && ((state_q == ST_IDLE) || ack);
        mem_wen = accept && !illegal && write;
        mem_ren = accept && !illegal && !write;
        if ((state_q == ST_RD) && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
            cap   = (cnt_q == 2'd1);
        end
        if (ack) begin
            state_d = ST_IDLE;
        end
        if (accept) begin
            if (illegal) begin
                state_d = ST_ERR;
            end else if (write) begin
                state_d = ST_WR;
            end else begin
                state_d = ST_RD;
                cnt_d   = 2'(RD_LATENCY);
            end
        end
    end

    // State and read-latency counter
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data capture, held until the next read
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= '0;
        end else if (cap) begin
            rdata_q <= mem_rdata;
        end
    end

    ahbsram_byteen_dec #(
        .DWIDTH (DWIDTH)
    ) u_dec (
        .en_i     (mem_wen),
        .size_i   (size),
        .off_i    (addr[K-1:0]),
        .byteen_o (mem_byteen)
    );

endmodule

// File: tb/tb_ahbsram_ctrl_pipe.sv
// Bench for ahbsram_ctrl_pipe: three configurations, one active at a time.
// Cycle-level reference model with a byte-addressed memory.
module tb_ahbsram_ctrl_pipe;

    typedef struct {
        bit        wr;
        bit [2:0]  size;
        bit [18:0] addr;
        bit [63:0] wdata;
        int        gap;
    } txn_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  size = 3'd0;
    logic [18:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] mem_rdata = '0;
    int          sel = 0;

    logic        req_a, req_b, req_c;
    logic        ack_a, ack_b, ack_c, err_a, err_b, err_c;
    logic        busy_a, busy_b, busy_c;
    logic        wen_a, wen_b, wen_c, ren_a, ren_b, ren_c;
    logic [31:0] rd_a, rd_c, mwd_a, mwd_c;
    logic [63:0] rd_b, mwd_b;
    logic [18:0] ma_a, ma_b, ma_c;
    logic [3:0]  be_a, be_c;
    logic [7:0]  be_b;

    logic        o_ack, o_err, o_busy, o_wen, o_ren;
    logic [7:0]  o_be;
    logic [18:0] o_ma;
    logic [63:0] o_rd, o_mwd;

    int          ntot = 0;
    int          nfail = 0;
    txn_t        q[$];
    logic [7:0]  mem [int];
    logic [63:0] rexp [3];

    always #5 clk = ~clk;

    assign req_a = req && (sel == 0);
    assign req_b = req && (sel == 1);
    assign req_c = req && (sel == 2);

    ahbsram_ctrl_pipe #(.DWIDTH(32), .AWIDTH(19), .RD_LATENCY(1)) u_a (
        .HCLK(clk), .aresetn(aresetn), .req(req_a), .write(write),
        .size(size), .addr(addr), .wdata(wdata[31:0]), .ack(ack_a),
        .err(err_a), .rdata(rd_a), .busy(busy_a), .mem_wen(wen_a),
        .mem_ren(ren_a), .mem_addr(ma_a), .mem_byteen(be_a),
        .mem_wdata(mwd_a), .mem_rdata(mem_rdata[31:0]));

    ahbsram_ctrl_pipe #(.DWIDTH(64), .AWIDTH(19), .RD_LATENCY(3)) u_b (
        .HCLK(clk), .aresetn(aresetn), .req(req_b), .write(write),
        .size(size), .addr(addr), .wdata(wdata), .ack(ack_b),
        .err(err_b), .rdata(rd_b), .busy(busy_b), .mem_wen(wen_b),
        .mem_ren(ren_b), .mem_addr(ma_b), .mem_byteen(be_b),
        .mem_wdata(mwd_b), .mem_rdata(mem_rdata));

    ahbsram_ctrl_pipe #(.DWIDTH(32), .AWIDTH(19), .RD_LATENCY(2)) u_c (
        .HCLK(clk), .aresetn(aresetn), .req(req_c), .write(write),
        .size(size), .addr(addr), .wdata(wdata[31:0]), .ack(ack_c),
        .err(err_c), .rdata(rd_c), .busy(busy_c), .mem_wen(wen_c),
        .mem_ren(ren_c), .mem_addr(ma_c), .mem_byteen(be_c),
        .mem_wdata(mwd_c), .mem_rdata(mem_rdata[31:0]));

    always_comb begin
        o_ack = ack_a; o_err = err_a; o_busy = busy_a;
        o_wen = wen_a; o_ren = ren_a; o_be = {4'b0, be_a};
        o_ma = ma_a; o_rd = {32'b0, rd_a}; o_mwd = {32'b0, mwd_a};
        if (sel == 1) begin
            o_ack = ack_b; o_err = err_b; o_busy = busy_b;
            o_wen = wen_b; o_ren = ren_b; o_be = be_b;
            o_ma = ma_b; o_rd = rd_b; o_mwd = mwd_b;
        end else if (sel == 2) begin
            o_ack = ack_c; o_err = err_c; o_busy = busy_c;
            o_wen = wen_c; o_ren = ren_c; o_be = {4'b0, be_c};
            o_ma = ma_c; o_rd = {32'b0, rd_c}; o_mwd = {32'b0, mwd_c};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nb_of(input int s);
        return (s == 1) ? 8 : 4;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 3 : 2);
    endfunction

    function automatic bit legal(input int s, input bit [2:0] sz,
                                 input bit [18:0] a);
        int bytes;
        bytes = 1 << sz;
        if (bytes > nb_of(s)) return 1'b0;
        return (int'(a) % bytes) == 0;
    endfunction

    function automatic logic [7:0] be_exp(input int s, input bit [2:0] sz,
                                          input bit [18:0] a);
        logic [7:0] be;
        int off;
        be = '0;
        off = int'(a) % nb_of(s);
        for (int i = 0; i < nb_of(s); i++)
            if (i >= off && i < off + (1 << sz)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] rd_word(input int s, input int waddr);
        logic [63:0] w;
        int key;
        w = '0;
        for (int i = 0; i < nb_of(s); i++) begin
            key = s * 1000000 + waddr * nb_of(s) + i;
            w[8*i +: 8] = mem.exists(key) ? mem[key] : 8'h00;
        end
        return w;
    endfunction

    // Runs every queued transaction on configuration s against the model
    task automatic run_q(input int s);
        bit          busy_m, ack_e, acc, nl, cap;
        int          left, gap_cnt, budget, nb;
        txn_t        cur, nxt;
        bit          cur_ill;
        logic [7:0]  be;
        logic [63:0] word, mask;
        busy_m = 0; left = 0; budget = 0; cur_ill = 0;
        cur = '{0, 0, 0, 0, 0};
        nxt = cur;
        nb = nb_of(s);
        mask = (nb == 8) ? '1 : 64'hFFFF_FFFF;
        sel = s;
        gap_cnt = (q.size() != 0) ? q[0].gap : 0;
        while ((q.size() != 0 || busy_m) && budget < 3000) begin
            budget++;
            ack_e = busy_m && (left == 0);
            acc = 0;
            if (!busy_m || ack_e) begin
                if (q.size() != 0 && gap_cnt == 0) begin
                    nxt = q.pop_front();
                    acc = 1;
                    req = 1'b1; write = nxt.wr; size = nxt.size;
                    addr = nxt.addr; wdata = nxt.wdata;
                    gap_cnt = (q.size() != 0) ? q[0].gap : 0;
                end else begin
                    req = 1'b0;
                    if (gap_cnt > 0) gap_cnt--;
                end
            end
            cap = busy_m && !cur.wr && !cur_ill && (left == 1);
            word = rd_word(s, int'(cur.addr) / nb);
            mem_rdata = cap ? word : {$urandom, $urandom};
            #4;
            nl = acc && legal(s, nxt.size, nxt.addr);
            be = (nl && nxt.wr) ? be_exp(s, nxt.size, nxt.addr) : 8'h00;
            chk("ack", o_ack, ack_e);
            chk("err", o_err, ack_e && cur_ill);
            chk("busy", o_busy, busy_m);
            chk("mem_wen", o_wen, nl && nxt.wr);
            chk("mem_ren", o_ren, nl && !nxt.wr);
            chk("mem_byteen", o_be, be);
            chk("rdata", o_rd, rexp[s]);
            if (nl) begin
                chk("mem_addr", o_ma, 19'(int'(nxt.addr) / nb));
                chk("mem_wdata", o_mwd, nxt.wdata & mask);
            end
            for (int i = 0; i < nb; i++)
                if (be[i])
                    mem[s * 1000000 + (int'(nxt.addr) / nb) * nb + i] =
                        nxt.wdata[8*i +: 8];
            if (cap) rexp[s] = word;
            if (acc) begin
                cur = nxt;
                cur_ill = !legal(s, nxt.size, nxt.addr);
                busy_m = 1;
                left = (cur_ill || nxt.wr) ? 0 : lat_of(s);
            end else if (ack_e) begin
                busy_m = 0;
            end else if (busy_m) begin
                left--;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        if (budget >= 3000) chk("timeout", 1, 0);
    endtask

    task automatic push(input bit wr, input bit [2:0] sz,
                        input bit [18:0] a, input bit [63:0] d,
                        input int gap);
        txn_t t;
        t.wr = wr; t.size = sz; t.addr = a; t.wdata = d; t.gap = gap;
        q.push_back(t);
    endtask

    task automatic push_rand(input int n);
        bit [2:0]  sz;
        bit [18:0] a;
        for (int i = 0; i < n; i++) begin
            sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3))
                                            : 3'($urandom_range(4, 7));
            a = 19'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0 && sz < 4)
                a = a & ~19'((1 << sz) - 1);
            push(1'($urandom_range(0, 1)), sz, a,
                 {$urandom, $urandom}, $urandom_range(0, 2));
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) rexp[s] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; req = 1'b1; #1;
            chk("rst_ack", o_ack, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_ren", o_ren, 0);
            chk("rst_rdata", o_rd, 0);
        end
        req = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;

        push(1, 3'd2, 19'h10, 64'hDEADBEEF, 0);
        push(0, 3'd2, 19'h10, 64'h0, 0);
        run_q(0);
        chk("deadbeef", o_rd, 64'hDEADBEEF);
        push(1, 3'd2, 19'h02, 64'h1234, 0);
        push(0, 3'd3, 19'h00, 64'h0, 0);
        push(1, 3'd1, 19'h06, 64'hABCD_0000, 1);
        push(0, 3'd0, 19'h07, 64'h0, 0);
        run_q(0);
        push_rand(60);
        run_q(0);

        push(1, 3'd0, 19'h0D, 64'h0000_AB00_0000_0000, 0);
        push(0, 3'd3, 19'h08, 64'h0, 0);
        run_q(1);
        chk("byte_lane5", o_rd[47:40], 8'hAB);
        push_rand(60);
        run_q(1);

        push_rand(40);
        run_q(2);

        sel = 2;
        req = 1'b1; write = 1'b0; size = 3'd2; addr = 19'h8;
        #4;
        chk("rst_pre_ren", o_ren, 1);
        @(posedge clk); #3;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_ack", o_ack, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_ren", o_ren, 0);
        chk("rst_mid_wen", o_wen, 0);
        chk("rst_mid_err", o_err, 0);
        chk("rst_mid_rdata", o_rd, 0);
        req = 1'b0;
        for (int s = 0; s < 3; s++) rexp[s] = '0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("post_rst_ack", o_ack, 0);
            chk("post_rst_busy", o_busy, 0);
            @(posedge clk); #1;
        end
        push(1, 3'd2, 19'h20, 64'h5555AAAA, 0);
        push(0, 3'd2, 19'h20, 64'h0, 0);
        run_q(2);
        chk("c_readback", o_rd, 64'h5555AAAA);

        $display("%0d/%0d checks passed", ntot - nfail, ntot);
        $finish;
    end

endmodule

// File: doc/ahbsram_ctrl_pipe.md
AHBSRAM_CTRL_PIPE -- requirements
Module: ahbsram_ctrl_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, memory/bus data width; legal values 32 and 64.
REQ-002 SHALL have parameter AWIDTH, default 19, byte-address width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, SRAM read latency in cycles; legal values 1 to 3.
REQ-004 SHALL have HCLK  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have aresetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have req  input  1  transfer request from the bus interface.
REQ-007 SHALL have write  input  1  1 = write, 0 = read.
REQ-008 SHALL have size  input  3  transfer size code: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-009 SHALL have addr  input  AWIDTH  byte address.
REQ-010 SHALL have wdata  input  DWIDTH  write data, lane-aligned.
REQ-011 SHALL have ack  output  1  transfer complete, one-cycle pulse.
REQ-012 SHALL have err  output  1  error qualifier, valid only with ack.
REQ-013 SHALL have rdata  output  DWIDTH  registered read data.
REQ-014 SHALL have busy  output  1  high when state is not IDLE.
REQ-015 SHALL have mem_wen, mem_ren  output  1  SRAM write/read strobes.
REQ-016 SHALL have mem_addr  output  AWIDTH  word address, addr shifted right by log2(DWIDTH/8), zero-filled at the top.
REQ-017 SHALL have mem_byteen  output  DWIDTH/8  byte write enables.
REQ-018 SHALL have mem_wdata  output  DWIDTH  equal to wdata.
REQ-019 SHALL have mem_rdata  input  DWIDTH  SRAM read data.

Function
REQ-020 SHALL implement states IDLE, WR, RD, ERR.
REQ-021 SHALL accept a request in any cycle where req=1 and the state is IDLE, or the state is any other state with ack=1 (back-to-back acceptance); call that cycle T.
REQ-022 SHALL treat a request as illegal when size > log2(DWIDTH/8), or when addr is not aligned to 2^size bytes.
REQ-023 On an illegal request the block SHALL assert no mem strobe and SHALL enter ERR; it SHALL assert ack=1 and err=1 in cycle T+1.
REQ-024 For a legal write, the block SHALL drive mem_wen=1 combinationally in cycle T with the decoded mem_byteen, enter WR, and assert ack in cycle T+1.
REQ-025 For a legal read, the block SHALL drive mem_ren=1 in cycle T and enter RD, with an internal counter loaded to RD_LATENCY.
REQ-026 The block SHALL load mem_rdata into rdata at the end of cycle T+RD_LATENCY, and SHALL assert ack in cycle T+RD_LATENCY+1.
REQ-027 rdata SHALL hold its value until the next read capture.
REQ-028 mem_byteen SHALL decode as follows:
- size 0: one bit at addr[k-1:0];
- size 1: two bits at the pair selected by addr;
- size 2: four bits;
- size 3: all eight bits.
k = log2(DWIDTH/8). When mem_wen=0, mem_byteen SHALL be all zero.
REQ-029 The requester SHALL hold req, write, size, addr and wdata stable from cycle T through the ack cycle.
REQ-030 A req asserted while busy=1 and ack=0 SHALL be ignored (no strobe, no state change).
REQ-031 In an ack cycle with req=0, the next state SHALL be IDLE.
REQ-032 ack SHALL never be high for two consecutive cycles unless a back-to-back transfer was accepted.
REQ-033 err SHALL be 0 whenever ack is 0.

Reset
REQ-034 On aresetn=0, the block SHALL immediately set: state = IDLE, read counter = 0, rdata = 0, and ack = err = busy = mem_wen = mem_ren = 0.
REQ-035 A transfer in flight at reset SHALL be abandoned; no ack SHALL follow the release of reset.
REQ-036 The first request SHALL be accepted in the first cycle after reset release.

Structure
REQ-037 Package ahbsram_pkg SHALL hold the state encoding, the size codes, and the constant function computing log2(DWIDTH/8).
REQ-038 Byte-enable decode SHALL be one sub-module, ahbsram_byteen_dec, parameterised by DWIDTH.
REQ-039 The read counter width SHALL be 2 bits.

Verification
REQ-040 Word write then read, DWIDTH=32, RD_LATENCY=1: write 0xDEADBEEF at addr 0x10 -> mem_byteen=0xF and mem_addr=0x4 in cycle T, ack at T+1; read of addr 0x10 -> ack at T+2 with rdata=0xDEADBEEF.
REQ-041 Byte write, DWIDTH=64: size 0 at addr 0x0D -> mem_byteen=0x20 and mem_addr=0x1.
REQ-042 RD_LATENCY=3: read issued at cycle T -> mem_ren high only in T, ack in T+4, busy high for T+1 through T+4.
REQ-043 Illegal requests: size 2 at addr 0x2, and size 3 with DWIDTH=32 -> no mem strobe, ack=err=1 in T+1.
REQ-044 Back-to-back: write accepted in its own ack cycle immediately followed by a read -> mem_ren in that same ack cycle, correct second ack, no lost transfer.
REQ-045 Reset mid-operation: aresetn low during RD with RD_LATENCY=2 -> all outputs 0 immediately, no ack after release.
